// File: rtl/scroll_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scroll_pkg
// Description : Shared types, widths and the raw-column mapping for the
//               scrolling message player.
// Revision    : 1.0 - initial release
// ============================================================================
package scroll_pkg;

    // Player control states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    // Width of one stored message word
    localparam int WORD_W    = 7;
    // Bit that marks a word as a font glyph rather than a raw column
    localparam int GLYPH_BIT = 6;
    // Columns per glyph held in the font ROM
    localparam int FONT_COLS = 8;

    // A raw word's six pixels sit in the middle of the 8-pixel column,
    // leaving the top and bottom LEDs dark.
    function automatic logic [7:0] raw_col(input logic [5:0] pixels);
        return {1'b0, pixels, 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/scroll_msg_player_glyph_font_rom.sv
`default_nettype none
// ============================================================================
// Module      : glyph_font_rom
// Description : Combinational 5x7 font, 64 glyphs x 8 columns, code is
//               ASCII-0x20. Column 0 and every undefined entry read as 0.
// Revision    : 1.0 - initial release
// ============================================================================
module glyph_font_rom
    import scroll_pkg::*;
(
    input  logic [5:0]                   code,
    input  logic [$clog2(FONT_COLS)-1:0] col,
    output logic [7:0]                   col_bits
);

    // Sparse case ROM; bit 0 is the top pixel of the column
    always_comb begin
        col_bits = 8'h00;
        case ({code, col})
            // '!'
            {6'h01, 3'd3}: col_bits = 8'h5F;
            // '0'
            {6'h10, 3'd1}: col_bits = 8'h3E;
            {6'h10, 3'd2}: col_bits = 8'h51;
            {6'h10, 3'd3}: col_bits = 8'h49;
            {6'h10, 3'd4}: col_bits = 8'h45;
            {6'h10, 3'd5}: col_bits = 8'h3E;
            // '1'
            {6'h11, 3'd2}: col_bits = 8'h42;
            {6'h11, 3'd3}: col_bits = 8'h7F;
            {6'h11, 3'd4}: col_bits = 8'h40;
            // 'A'
            {6'h21, 3'd1}: col_bits = 8'h7C;
            {6'h21, 3'd2}: col_bits = 8'h12;
            {6'h21, 3'd3}: col_bits = 8'h11;
            {6'h21, 3'd4}: col_bits = 8'h11;
            {6'h21, 3'd5}: col_bits = 8'h12;
            {6'h21, 3'd6}: col_bits = 8'h7C;
            // 'B'
            {6'h22, 3'd1}: col_bits = 8'h7F;
            {6'h22, 3'd2}: col_bits = 8'h49;
            {6'h22, 3'd3}: col_bits = 8'h49;
            {6'h22, 3'd4}: col_bits = 8'h49;
            {6'h22, 3'd5}: col_bits = 8'h36;
            // 'H'
            {6'h28, 3'd1}: col_bits = 8'h7F;
            {6'h28, 3'd2}: col_bits = 8'h08;
            {6'h28, 3'd3}: col_bits = 8'h08;
            {6'h28, 3'd4}: col_bits = 8'h08;
            {6'h28, 3'd5}: col_bits = 8'h7F;
            // 'I'
            {6'h29, 3'd2}: col_bits = 8'h41;
            {6'h29, 3'd3}: col_bits = 8'h7F;
            {6'h29, 3'd4}: col_bits = 8'h41;
            default:       col_bits = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/scroll_msg_player.sv
`default_nettype none
// ============================================================================
// Module      : scroll_msg_player
// Description : Message store plus tick-paced column scroller. Words are
//               either raw columns or font glyphs expanded to GLYPH_COLS
//               columns; playback is one-shot or looping.
// Revision    : 1.0 - initial release
// ============================================================================
module scroll_msg_player
    import scroll_pkg::*;
#(
    parameter int WORD_COUNT = 20,
    parameter int GLYPH_COLS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              clr,
    input  logic              play,
    input  logic              loop,
    input  logic              tick,
    output logic [7:0]        col_out,
    output logic              col_valid,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int PTR_W  = $clog2(WORD_COUNT);
    localparam int FILL_W = $clog2(WORD_COUNT + 1);
    localparam int COL_W  = $clog2(GLYPH_COLS);
    localparam int ROM_CW = $clog2(FONT_COLS);

    state_t             state_q,   state_d;
    logic [FILL_W-1:0]  fill_q,    fill_d;
    logic [PTR_W-1:0]   rd_ptr_q,  rd_ptr_d;
    logic [COL_W-1:0]   col_q,     col_d;
    logic [WORD_W-1:0]  mem_q [WORD_COUNT];
    logic [WORD_W-1:0]  mem_d [WORD_COUNT];
    logic [7:0]         col_out_q, col_out_d;
    logic               col_valid_q, col_valid_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic               overflow_q, overflow_d;
    // Set when a one-shot pass completes; a still-high play must drop
    // before it can start another pass, otherwise a level play would
    // immediately replay the message.
    logic               rearm_q,   rearm_d;

    logic [WORD_W-1:0]  cur_word;
    logic               is_glyph;
    logic [7:0]         glyph_bits;
    logic               last_col;
    logic               last_word;

    assign cur_word  = mem_q[rd_ptr_q];
    assign is_glyph  = cur_word[GLYPH_BIT];
    assign last_col  = !is_glyph || (col_q == COL_W'(GLYPH_COLS - 1));
    assign last_word = (FILL_W'(rd_ptr_q) == (fill_q - FILL_W'(1)));

    glyph_font_rom u_font (
        .code     (cur_word[5:0]),
        .col      (ROM_CW'(col_q)),
        .col_bits (glyph_bits)
    );

    // Next-state logic for the store, the FSM, counters and outputs
    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        rd_ptr_d    = rd_ptr_q;
        col_d       = col_q;
        mem_d       = mem_q;
        col_out_d   = col_out_q;
        col_valid_d = 1'b0;
        done_d      = 1'b0;
        overflow_d  = 1'b0;
        rearm_d     = rearm_q;

        case (state_q)
            IDLE: begin
                col_out_d = 8'h00;
                if (!play) begin
                    rearm_d = 1'b0;
                end
                if (clr) begin
                    fill_d = '0;
                end else if (wr_en) begin
                    if (fill_q < FILL_W'(WORD_COUNT)) begin
                        mem_d[fill_q[PTR_W-1:0]] = wr_data;
                        fill_d = fill_q + FILL_W'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                // Start decision sees this cycle's write so the pass uses
                // the updated fill.
                if (play && !rearm_q && (fill_d != '0)) begin
                    state_d  = PLAY;
                    rd_ptr_d = '0;
                    col_d    = '0;
                end
            end

            PLAY: begin
                // done_q marks the cycle showing the final one-shot column;
                // the blanking return to IDLE follows it.
                if (!play || done_q) begin
                    state_d   = IDLE;
                    col_out_d = 8'h00;
                end else if (tick) begin
                    col_valid_d = 1'b1;
                    col_out_d   = is_glyph ? glyph_bits : raw_col(cur_word[5:0]);
                    if (last_col) begin
                        col_d = '0;
                        if (last_word) begin
                            rd_ptr_d = '0;
                            if (!loop) begin
                                done_d  = 1'b1;
                                rearm_d = 1'b1;
                            end
                        end else begin
                            rd_ptr_d = rd_ptr_q + PTR_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                col_out_d = 8'h00;
            end
        endcase

        busy_d = (state_d == PLAY);
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fill_q      <= '0;
            rd_ptr_q    <= '0;
            col_q       <= '0;
            mem_q       <= '{default: '0};
            col_out_q   <= 8'h00;
            col_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            rearm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            rd_ptr_q    <= rd_ptr_d;
            col_q       <= col_d;
            mem_q       <= mem_d;
            col_out_q   <= col_out_d;
            col_valid_q <= col_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            rearm_q     <= rearm_d;
        end
    end

    assign col_out   = col_out_q;
    assign col_valid = col_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_scroll_msg_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_scroll_msg_player
// Description : Directed self-checking bench for scroll_msg_player.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scroll_msg_player;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [6:0] wr_data;
    logic       clr;
    logic       play;
    logic       loop;
    logic       tick;
    logic [7:0] col_out;
    logic       col_valid;
    logic       busy;
    logic       done;
    logic       overflow;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] a_cols [8] = '{8'h00, 8'h7C, 8'h12, 8'h11, 8'h11, 8'h12, 8'h7C, 8'h00};

    always #5 clk = ~clk;

    scroll_msg_player #(
        .WORD_COUNT (20),
        .GLYPH_COLS (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .clr       (clr),
        .play      (play),
        .loop      (loop),
        .tick      (tick),
        .col_out   (col_out),
        .col_valid (col_valid),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [6:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cnt;
        logic       seen_done;
        logic       ovf_seen;
        logic [7:0] last_col;
        logic [7:0] exp_col;

        rst = 1'b1; wr_en = 1'b0; wr_data = 7'h00; clr = 1'b0;
        play = 1'b0; loop = 1'b0; tick = 1'b0;
        step(); step();
        chk("rst_col_out",   col_out,        8'h00);
        chk("rst_col_valid", 8'(col_valid),  8'h00);
        chk("rst_busy",      8'(busy),       8'h00);
        chk("rst_done",      8'(done),       8'h00);
        chk("rst_overflow",  8'(overflow),   8'h00);
        rst = 1'b0;
        step();

        // Reset in the middle of looping playback
        wr(7'h15);
        loop = 1'b1; play = 1'b1;
        step();
        chk("rp_busy", 8'(busy), 8'h01);
        tick = 1'b1;
        step(); step();
        chk("rp_valid", 8'(col_valid), 8'h01);
        chk("rp_col",   col_out,       8'h2A);
        #3 rst = 1'b1;
        #1;
        chk("rp_async_col",   col_out,       8'h00);
        chk("rp_async_valid", 8'(col_valid), 8'h00);
        chk("rp_async_busy",  8'(busy),      8'h00);
        step();
        rst = 1'b0;
        step(); step();
        chk("rp_empty_busy",  8'(busy),      8'h00);
        chk("rp_empty_valid", 8'(col_valid), 8'h00);

        // One-shot single raw word
        play = 1'b0; tick = 1'b0; loop = 1'b0;
        step();
        wr(7'h15);
        play = 1'b1;
        step();
        chk("raw_busy_start",  8'(busy),      8'h01);
        chk("raw_valid_start", 8'(col_valid), 8'h00);
        tick = 1'b1;
        step();
        chk("raw_valid", 8'(col_valid), 8'h01);
        chk("raw_col",   col_out,       8'h2A);
        chk("raw_done",  8'(done),      8'h01);
        chk("raw_busy",  8'(busy),      8'h01);
        step();
        chk("raw_busy_fall", 8'(busy),      8'h00);
        chk("raw_valid2",    8'(col_valid), 8'h00);
        chk("raw_done2",     8'(done),      8'h00);
        chk("raw_col_blank", col_out,       8'h00);
        step();
        chk("raw_valid3", 8'(col_valid), 8'h00);
        chk("raw_busy3",  8'(busy),      8'h00);

        // One-shot glyph 'A'
        play = 1'b0; tick = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        wr(7'h61);
        play = 1'b1;
        step();
        tick = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("a_col%0d", i),   col_out,       a_cols[i]);
            chk($sformatf("a_valid%0d", i), 8'(col_valid), 8'h01);
            chk($sformatf("a_done%0d", i),  8'(done),      (i == 7) ? 8'h01 : 8'h00);
        end
        tick = 1'b0;
        step();
        chk("a_busy_end", 8'(busy), 8'h00);

        // Looping glyph 'A' plus raw 7'h3F, then abort mid-glyph
        play = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        wr(7'h61);
        wr(7'h3F);
        loop = 1'b1; play = 1'b1;
        step();
        tick = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            exp_col = ((i % 9) < 8) ? a_cols[i % 9] : 8'h7E;
            chk($sformatf("lp_col%0d", i),  col_out,  exp_col);
            chk($sformatf("lp_done%0d", i), 8'(done), 8'h00);
        end
        play = 1'b0;
        step();
        chk("abort_col",   col_out,       8'h00);
        chk("abort_busy",  8'(busy),      8'h00);
        chk("abort_valid", 8'(col_valid), 8'h00);
        chk("abort_done",  8'(done),      8'h00);

        // Overflow, writes during PLAY, clr beating wr_en
        tick = 1'b0; loop = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wr(7'(i));
        end
        chk("ovf_full_no", 8'(overflow), 8'h00);
        wr(7'h05);
        chk("ovf_pulse", 8'(overflow), 8'h01);
        step();
        chk("ovf_width", 8'(overflow), 8'h00);
        play = 1'b1;
        step();
        wr_en = 1'b1; wr_data = 7'h01; tick = 1'b1;
        cnt = 0; seen_done = 1'b0; ovf_seen = 1'b0; last_col = 8'h00;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            step();
            if (col_valid) cnt++;
            if (overflow)  ovf_seen = 1'b1;
            if (done) begin
                seen_done = 1'b1;
                last_col  = col_out;
            end
        end
        wr_en = 1'b0;
        chk("full_done_seen", 8'(seen_done), 8'h01);
        chk("full_col_count", 8'(cnt),       8'd20);
        chk("full_last_col",  last_col,      8'h26);
        chk("full_no_ovf",    8'(ovf_seen),  8'h00);
        play = 1'b0; tick = 1'b0;
        step();
        clr = 1'b1; wr_en = 1'b1; wr_data = 7'h15;
        step();
        clr = 1'b0; wr_en = 1'b0; play = 1'b1; tick = 1'b1;
        step(); step();
        chk("clr_wins_busy",  8'(busy),      8'h00);
        chk("clr_wins_valid", 8'(col_valid), 8'h00);

        // Ticks spaced five cycles apart
        play = 1'b0; tick = 1'b0;
        step();
        wr(7'h61);
        loop = 1'b0; play = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            chk($sformatf("sp_valid%0d", k), 8'(col_valid), 8'h01);
            chk($sformatf("sp_col%0d", k),   col_out,       a_cols[k]);
            if (k < 7) begin
                for (int j = 0; j < 4; j++) begin
                    step();
                    chk($sformatf("sp_hold_valid%0d_%0d", k, j), 8'(col_valid), 8'h00);
                    chk($sformatf("sp_hold_col%0d_%0d", k, j),   col_out,       a_cols[k]);
                end
            end
        end
        chk("sp_done", 8'(done), 8'h01);
        play = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scroll_msg_player.md
Name: scroll_msg_player

Overview:
- Parametrised message store and column-scroller for the 8-segment column LED/display output of the TT tile.
- Host loads up to WORD_COUNT 7-bit words, then starts playback on a tick-paced schedule.
- Each word is either a raw column or a font glyph index. A glyph expands to GLYPH_COLS columns from an ASCII-0x20-offset 5x7 font ROM.
- New over the previous generation: reset, fill tracking, explicit play/clear, loop or one-shot mode, rate tick, done/overflow status.

Parameters:
- WORD_COUNT, 20, message depth in words, 2..64.
- GLYPH_COLS, 8, columns emitted per glyph word, 6..8; columns 0..GLYPH_COLS-1 of the ROM are used.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write one word into the message store.
- wr_data  in  7  bit6=1 glyph word (bits5:0 = ASCII-0x20); bit6=0 raw word (bits5:0 = column pixels).
- clr  in  1  empty the store (fill := 0).
- play  in  1  level; high requests/sustains playback.
- loop  in  1  1 = wrap to word 0 after the last word; 0 = one-shot. Sampled each word boundary.
- tick  in  1  advance enable; one column is emitted per tick.
- col_out  out  8  current display column.
- col_valid  out  1  one-cycle pulse: col_out updated this cycle.
- busy  out  1  high in PLAY.
- done  out  1  one-cycle pulse with the final column of a one-shot pass.
- overflow  out  1  one-cycle pulse on wr_en while full.

Behaviour:
- Reset (async, rst high):
  - state=IDLE; fill, rd_ptr and col all 0.
  - col_out=0; col_valid, busy, done and overflow all 0.
  - Store contents are cleared to 0.
- Store: WORD_COUNT x 7 array, written at index fill. Writes are accepted only in IDLE.
- IDLE:
  - clr: fill:=0. clr wins over a simultaneous wr_en.
  - wr_en && fill<WORD_COUNT: mem[fill]:=wr_data, fill++.
  - wr_en && fill==WORD_COUNT: data is dropped and overflow pulses.
  - play && fill>0: go to PLAY, rd_ptr:=0, col:=0.
  - play && fill==0: stay in IDLE.
  - play and wr_en in the same cycle: the write happens; PLAY starts next cycle with the updated fill.
- PLAY:
  - wr_en and clr are ignored; overflow is not raised.
  - busy=1.
  - Each tick: col_out and col_valid are registered one cycle after the tick edge (latency 1).
  - Raw word w: col_out={1'b0,w[5:0],1'b0}. Exactly one column, then advance to the next word.
  - Glyph word w: col_out=font(w[5:0], col), for col=0..GLYPH_COLS-1. Advance to the next word after column GLYPH_COLS-1.
  - Advance when rd_ptr==fill-1 (the word boundary), as follows.
  - With loop=1: rd_ptr:=0 and playback continues.
  - With loop=0: done pulses together with the last col_valid, and the next state is IDLE. fill is kept, so play can replay the message.
  - Without tick: all state holds; col_out holds; col_valid=0.
  - play deasserted: abort to IDLE on the next edge. col_out:=0, no done, no col_valid that cycle even if tick is high.
- IDLE output: col_out=0 in every IDLE cycle (load-mode blanking). col_valid=0.
- Counters:
  - rd_ptr is $clog2(WORD_COUNT) bits and wraps only at fill-1, never at WORD_COUNT.
  - col is $clog2(GLYPH_COLS) bits, reset to 0 at every word boundary.
- Font ROM:
  - 64 glyphs x 8 columns, combinational, indexed {code,col[2:0]}.
  - Column 0 and undefined entries are 0.
  - Code 0x00 (space) is all-zero.
- Reset mid-PLAY: immediate IDLE, fill=0, outputs 0.

Decomposition:
- Package scroll_pkg holds:
  - state enum {IDLE, PLAY};
  - WORD_W=7;
  - GLYPH_BIT=6;
  - FONT_COLS=8;
  - the raw-column mapping function.
- Sub-module glyph_font_rom: input code[5:0], col[2:0]; output col_bits[7:0]; pure case ROM.
- The top holds the store, the FSM and the counters.

Test Plan:
- Reset during PLAY with loop=1:
  - Required: all outputs go to 0 asynchronously.
  - After release: play with fill==0 leaves busy=0.
- Load raw 7'h15, loop=0, play=1, 3 ticks:
  - One col_valid with col_out=8'h2A.
  - done pulses in the same cycle; busy falls next cycle.
  - The later ticks produce nothing.
- Load glyph 7'h61 ('A'), GLYPH_COLS=8, one-shot:
  - Columns are 00,7C,12,11,11,12,7C,00.
  - done pulses with the 8th column.
- Load 2 words (glyph 'A', raw 7'h3F), loop=1, 20 ticks:
  - Sequence is 9 columns: 'A' columns then 7E; the sequence repeats.
  - done never pulses.
  - Deasserting play mid-glyph: col_out=0 next cycle, busy=0.
- Write WORD_COUNT+1 words:
  - The last write pulses overflow; fill=WORD_COUNT.
  - clr together with wr_en leaves fill=0.
  - wr_en during PLAY does not change fill.
- Ticks spaced 5 cycles apart:
  - col_out holds between ticks.
  - col_valid is exactly 1 cycle wide, one cycle after each tick.
